uart_rx_cfg: RTL and testbench

Parametrised UART receiver: the next generation of the project's fixed 8N1 receiver. It adds a configurable bit period, data width, parity and stop-bit count, rejects false start bits and reports parity, framing and overrun errors. It sits between the RX pin and the command/packet layer, and presents each received word with a `rdy`/`clr_rdy` handshake.

---
 rtl/uart_rx_cfg_if.sv | 33 +++
 rtl/uart_rx_cfg.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line and consumer handshake of the configurable
// UART receiver; master is the receiver, slave is the consumer side.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 RX;
    logic                 clr_rdy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rdy;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        input  RX,
        input  clr_rdy,
        output rx_data,
        output rdy,
        output parity_err,
        output frame_err,
        output overrun
    );

    modport slave (
        output RX,
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  parity_err,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with configurable bit period, word width,
// parity and stop bits; reports parity, framing and overrun errors.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_cfg_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Entry cycle counts as the first tick, so sample 0 lands at t + C/2
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY != 0);
    localparam logic          ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic [CW-1:0]        r_baud;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rdy;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_fall;
    logic w_tick;
    logic w_par_x;
    logic w_start;
    logic w_shift;
    logic w_par_smp;
    logic w_stop_smp;
    logic w_done;

    assign w_fall  = r_prev & ~r_sync2;
    assign w_tick  = (r_baud == '0);
    assign w_par_x = (^r_shift) ^ r_sync2;

    assign bus.rx_data    = r_rx_data;
    assign bus.rdy        = r_rdy;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= bus.RX;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_fall) w_next = S_START;
            end
            S_START: begin
                if (w_tick) w_next = r_sync2 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_tick && r_bit == LAST_DATA)
                    w_next = HAS_PAR ? S_PAR : S_STOP;
            end
            S_PAR: begin
                if (w_tick) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_tick && r_bit == LAST_STOP) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start    = 1'b0;
        w_shift    = 1'b0;
        w_par_smp  = 1'b0;
        w_stop_smp = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            S_IDLE: w_start   = w_fall;
            S_DATA: w_shift   = w_tick;
            S_PAR:  w_par_smp = w_tick;
            S_STOP: begin
                w_stop_smp = w_tick;
                w_done     = w_tick && (r_bit == LAST_STOP);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud <= HALF_M1;
            r_bit  <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_baud <= HALF_M1;
            end else if (w_tick) begin
                r_baud <= FULL_M1;
            end else begin
                r_baud <= r_baud - 1'b1;
            end
            // Bit counter restarts on every state change
            if (w_next != r_state) begin
                r_bit <= '0;
            end else if (w_shift || w_stop_smp) begin
                r_bit <= r_bit + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_par_err <= 1'b0;
                r_frm_err <= 1'b0;
            end
            if (w_shift) begin
                r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
            end
            if (w_par_smp) begin
                r_par_err <= ODD ? ~w_par_x : w_par_x;
            end
            if (w_stop_smp && !r_sync2) begin
                r_frm_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data    <= '0;
            r_rdy        <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_done) begin
            r_rx_data    <= r_shift;
            r_parity_err <= r_par_err;
            r_frame_err  <= r_frm_err | ~r_sync2;
            r_rdy        <= 1'b1;
            if (bus.clr_rdy) begin
                r_overrun <= 1'b0;
            end else if (r_rdy) begin
                r_overrun <= 1'b1;
            end
        end else if (bus.clr_rdy) begin
            r_rdy     <= 1'b0;
            r_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed scoreboard bench for three receiver builds
// (8N1, 8E1, 7N2) at 16 clocks per bit.
module tb_uart_rx_cfg;
    localparam int C = 16;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    typedef struct packed {
        logic [8:0] d;
        logic       rdy;
        logic       pe;
        logic       fe;
        logic       ov;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg_if #(.DATA_BITS(8)) a_if ();
    uart_rx_cfg_if #(.DATA_BITS(8)) b_if ();
    uart_rx_cfg_if #(.DATA_BITS(7)) c_if ();

    uart_rx_cfg #(
        .CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u_a (.clk(clk), .rst(rst), .bus(a_if.master));

    uart_rx_cfg #(
        .CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) u_b (.clk(clk), .rst(rst), .bus(b_if.master));

    uart_rx_cfg #(
        .CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)
    ) u_c (.clk(clk), .rst(rst), .bus(c_if.master));

    function automatic int cfg_nd(input int u);
        return (u == 2) ? 7 : 8;
    endfunction

    function automatic int cfg_pm(input int u);
        return (u == 1) ? 2 : 0;
    endfunction

    function automatic int cfg_ns(input int u);
        return (u == 2) ? 2 : 1;
    endfunction

    // Cycles from driving the start bit to the first cycle rdy reads 1
    function automatic int lat(input int u);
        int k;
        k = cfg_nd(u) + ((cfg_pm(u) != 0) ? 1 : 0) + cfg_ns(u);
        return 3 + C / 2 + k * C;
    endfunction

    function automatic obs_t get(input int u);
        obs_t o;
        o = '0;
        case (u)
            0: o = {1'b0, a_if.rx_data, a_if.rdy, a_if.parity_err,
                    a_if.frame_err, a_if.overrun};
            1: o = {1'b0, b_if.rx_data, b_if.rdy, b_if.parity_err,
                    b_if.frame_err, b_if.overrun};
            default: o = {2'b0, c_if.rx_data, c_if.rdy, c_if.parity_err,
                          c_if.frame_err, c_if.overrun};
        endcase
        return o;
    endfunction

    task automatic set_rx(input int u, input logic v);
        case (u)
            0: a_if.RX = v;
            1: b_if.RX = v;
            default: c_if.RX = v;
        endcase
    endtask

    task automatic set_clr(input int u, input logic v);
        case (u)
            0: a_if.clr_rdy = v;
            1: b_if.clr_rdy = v;
            default: c_if.clr_rdy = v;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int u, input exp_t e);
        case (u)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int u);
        case (u)
            0: return qa.size();
            1: return qb.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic pop(input int u, output exp_t e);
        case (u)
            0: e = qa.pop_front();
            1: e = qb.pop_front();
            default: e = qc.pop_front();
        endcase
    endtask

    task automatic pop_chk(input int u, input string tag);
        exp_t e;
        obs_t o;
        int   sz;
        sz = qsize(u);
        chk({tag, "_sb"}, 32'(sz > 0), 32'd1);
        if (sz > 0) begin
            pop(u, e);
            o = get(u);
            chk({tag, "_data"}, 32'(o.d), 32'(e.d));
            chk({tag, "_pe"}, 32'(o.pe), 32'(e.pe));
            chk({tag, "_fe"}, 32'(o.fe), 32'(e.fe));
            chk({tag, "_rdy"}, 32'(o.rdy), 32'd1);
        end
    endtask

    // Drives n bits of C cycles each; records first rdy rise relative to start
    task automatic send(input int u, input logic [15:0] bits, input int n,
                        input int clr_at, output int rise);
        obs_t o;
        logic pr;
        int   st;
        st   = cyc;
        rise = -1;
        o    = get(u);
        pr   = o.rdy;
        for (int b = 0; b < n; b++) begin
            set_rx(u, bits[b]);
            for (int k = 0; k < C; k++) begin
                @(negedge clk);
                set_clr(u, (cyc - st == clr_at) ? 1'b1 : 1'b0);
                o = get(u);
                if (rise < 0 && !pr && o.rdy) rise = cyc - st;
                pr = o.rdy;
            end
        end
        set_clr(u, 1'b0);
    endtask

    task automatic frame(input int u, input logic [8:0] d, input logic pflip,
                         input logic [1:0] stops, input int clr_at,
                         input string tag, output int rise);
        logic [15:0] bits;
        logic        pb;
        logic        x;
        exp_t        e;
        int          n;
        bits = '0;
        e    = '0;
        n    = 1;
        for (int i = 0; i < cfg_nd(u); i++) begin
            e.d[i]  = d[i];
            bits[n] = d[i];
            n++;
        end
        if (cfg_pm(u) != 0) begin
            pb      = ((cfg_pm(u) == 2) ? (^e.d) : ~(^e.d)) ^ pflip;
            bits[n] = pb;
            n++;
            x    = (^e.d) ^ pb;
            e.pe = (cfg_pm(u) == 2) ? x : ~x;
        end
        for (int s = 0; s < cfg_ns(u); s++) begin
            bits[n] = stops[s];
            if (!stops[s]) e.fe = 1'b1;
            n++;
        end
        push(u, e);
        send(u, bits, n, clr_at, rise);
        pop_chk(u, tag);
    endtask

    task automatic clr(input int u);
        set_clr(u, 1'b1);
        @(negedge clk);
        set_clr(u, 1'b0);
    endtask

    initial begin
        int          r;
        int          rises;
        logic        pr;
        obs_t        o;
        obs_t        ex;
        logic [15:0] fb;

        a_if.RX = 1'b1;
        b_if.RX = 1'b1;
        c_if.RX = 1'b1;
        a_if.clr_rdy = 1'b0;
        b_if.clr_rdy = 1'b0;
        c_if.clr_rdy = 1'b0;

        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) chk("rst_hold", 32'(get(u)), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int u = 0; u < 3; u++) chk("rst_idle", 32'(get(u)), 32'd0);

        // 8N1 0xA5 with exact rdy timing, then acknowledge
        frame(0, 9'h0A5, 1'b0, 2'b11, -1, "t1", r);
        chk("t1_lat", 32'(r), 32'(lat(0)));
        clr(0);
        o = get(0);
        chk("t1_clr", 32'(o.rdy), 32'd0);

        // 8E1 0x03, good then bad parity
        frame(1, 9'h003, 1'b0, 2'b11, -1, "t2a", r);
        chk("t2a_lat", 32'(r), 32'(lat(1)));
        clr(1);
        frame(1, 9'h003, 1'b1, 2'b11, -1, "t2b", r);
        o = get(1);
        chk("t2b_pe", 32'(o.pe), 32'd1);

        // 7N2 0x55 with bad second stop, then a break
        frame(2, 9'h055, 1'b0, 2'b01, -1, "t3", r);
        o = get(2);
        chk("t3_fe", 32'(o.fe), 32'd1);
        clr(2);
        rises = 0;
        pr    = 1'b0;
        repeat (40 * C) begin
            @(negedge clk);
            o = get(2);
            if (!pr && o.rdy) rises++;
            pr = o.rdy;
        end
        chk("t3_brk_rise", 32'(rises), 32'd0);
        chk("t3_brk_rdy", 32'(o.rdy), 32'd0);
        set_rx(2, 1'b1);
        repeat (2 * C) @(negedge clk);
        frame(2, 9'h02A, 1'b0, 2'b11, -1, "t3b", r);
        chk("t3b_lat", 32'(r), 32'(lat(2)));
        clr(2);

        // False start glitch leaves outputs untouched
        set_rx(0, 1'b0);
        repeat (5) @(negedge clk);
        set_rx(0, 1'b1);
        repeat (2 * C) @(negedge clk);
        ex = {9'h0A5, 4'b0000};
        chk("t4_quiet", 32'(get(0)), 32'(ex));
        frame(0, 9'h03C, 1'b0, 2'b11, -1, "t4", r);
        chk("t4_lat", 32'(r), 32'(lat(0)));
        clr(0);

        // Overrun set, cleared, and ack coinciding with completion
        frame(0, 9'h011, 1'b0, 2'b11, -1, "t5a", r);
        chk("t5a_lat", 32'(r), 32'(lat(0)));
        frame(0, 9'h022, 1'b0, 2'b11, -1, "t5b", r);
        o = get(0);
        chk("t5b_ov", 32'(o.ov), 32'd1);
        clr(0);
        o = get(0);
        chk("t5_clr", 32'({o.rdy, o.ov}), 32'd0);
        frame(0, 9'h044, 1'b0, 2'b11, -1, "t5c", r);
        frame(0, 9'h055, 1'b0, 2'b11, -1, "t5d", r);
        o = get(0);
        chk("t5d_ov", 32'(o.ov), 32'd1);
        frame(0, 9'h066, 1'b0, 2'b11, lat(0) - 1, "t5e", r);
        o = get(0);
        chk("t5e_ov", 32'(o.ov), 32'd0);
        frame(0, 9'h077, 1'b0, 2'b11, -1, "t5f", r);
        o = get(0);
        chk("t5f_ov", 32'(o.ov), 32'd1);

        // Reset during data bit 4 clears outputs without a clock edge
        fb = {6'b0, 1'b1, 8'hC3, 1'b0};
        send(0, fb, 5, -1, r);
        set_rx(0, fb[5]);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_a", 32'(get(0)), 32'd0);
        chk("t6_rst_b", 32'(get(1)), 32'd0);
        set_rx(0, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2 * C) @(negedge clk);
        frame(0, 9'h0C3, 1'b0, 2'b11, -1, "t6", r);
        chk("t6_lat", 32'(r), 32'(lat(0)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
